// File: rtl/fetch_align_buffer_if.sv
// ============================================================================
// fetch_align_buffer_if : fetch-side and decode-side handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_align_buffer_if;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        instrD_valid;
  logic        instrD_ready;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        is_compressedD;

  modport master (
    output fetch_valid, fetch_data, flush, flush_pc, instrD_ready,
    input  fetch_ready, instrD_valid, instrD, pcD, is_compressedD
  );

  modport slave (
    input  fetch_valid, fetch_data, flush, flush_pc, instrD_ready,
    output fetch_ready, instrD_valid, instrD, pcD, is_compressedD
  );
endinterface

`default_nettype wire

// File: rtl/fetch_align_buffer.sv
// ============================================================================
// fetch_align_buffer : realigns 32-bit fetch words into 16/32-bit instructions
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_align_buffer_if.slave  bus
);

  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [2:0]  count_q;
  logic [31:0] pc_q;
  logic        drop_first_q;

  logic        head_is_c;
  logic        instr_ok;
  logic        push;
  logic        pop;
  logic [2:0]  push_n;
  logic [2:0]  pop_n;
  logic [2:0]  base;

  // Redirect targets are halfword aligned, so the LSB carries no information.
  logic unused_flush_pc_lsb;
  assign unused_flush_pc_lsb = bus.flush_pc[0];

  assign head_is_c = (hw_q[0][1:0] != 2'b11);
  assign instr_ok  = head_is_c ? (count_q >= 3'd1) : (count_q >= 3'd2);

  assign bus.fetch_ready    = (count_q <= 3'd2);
  assign bus.instrD_valid   = instr_ok;
  assign bus.pcD            = pc_q;
  assign bus.is_compressedD = instr_ok & head_is_c;
  assign bus.instrD         = !instr_ok ? 32'h0 :
                              head_is_c ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};

  assign push   = bus.fetch_valid && bus.fetch_ready && !bus.flush;
  assign pop    = instr_ok && bus.instrD_ready && !bus.flush;
  assign push_n = !push ? 3'd0 : (drop_first_q ? 3'd1 : 3'd2);
  assign pop_n  = !pop  ? 3'd0 : (head_is_c ? 3'd1 : 3'd2);
  assign base   = count_q - pop_n;

  // Shift out the consumed halfwords, then append the new ones behind the survivors.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hw_d[i] = ((3'(i) + pop_n) < 3'd4) ? hw_q[2'(3'(i) + pop_n)] : 16'h0;
      if (push && (3'(i) == base)) begin
        hw_d[i] = drop_first_q ? bus.fetch_data[31:16] : bus.fetch_data[15:0];
      end
      if (push && !drop_first_q && (3'(i) == (base + 3'd1))) begin
        hw_d[i] = bus.fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= 3'd0;
      pc_q         <= RESET_PC;
      drop_first_q <= RESET_PC[1];
      for (int i = 0; i < 4; i++) begin
        hw_q[i] <= 16'h0;
      end
    end else if (bus.flush) begin
      count_q      <= 3'd0;
      pc_q         <= {bus.flush_pc[31:1], 1'b0};
      drop_first_q <= bus.flush_pc[1];
    end else begin
      count_q <= count_q + push_n - pop_n;
      hw_q    <= hw_d;
      if (pop) begin
        pc_q <= pc_q + (head_is_c ? 32'd2 : 32'd4);
      end
      if (push) begin
        drop_first_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_align_buffer.sv
// ============================================================================
// tb_fetch_align_buffer : directed scoreboard bench for fetch_align_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_align_buffer;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  fetch_align_buffer_if bus ();

  fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc, input logic c);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.c     = c;
    sb.push_back(e);
  endtask

  // Compare any instruction transfer at the falling edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset && bus.instrD_valid && bus.instrD_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_instr", bus.instrD, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("instrD", bus.instrD, e.instr);
        chk("pcD", bus.pcD, e.pc);
        chk("is_compressedD", {31'h0, bus.is_compressedD}, {31'h0, e.c});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    bus.fetch_valid  = 1'b0;
    bus.fetch_data   = 32'h0;
    bus.flush        = 1'b0;
    bus.flush_pc     = 32'h0;
    bus.instrD_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", {31'h0, bus.instrD_valid}, 32'h0);
    chk("rst_fetch_ready", {31'h0, bus.fetch_ready}, 32'h1);
    chk("rst_pcD", bus.pcD, 32'h0);
    chk("rst_instrD", bus.instrD, 32'h0);
    chk("rst_is_c", {31'h0, bus.is_compressedD}, 32'h0);

    // Single 32-bit instruction, one-cycle latency
    expect_instr(32'h0050_0093, 32'h0, 1'b0);
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'h0050_0093;
    bus.instrD_ready = 1'b1;
    tick();
    bus.fetch_valid = 1'b0;
    chk("latency_valid", {31'h0, bus.instrD_valid}, 32'h1);
    tick();

    // Two compressed instructions from one word
    expect_instr(32'h0000_0505, 32'h4, 1'b1);
    expect_instr(32'h0000_4505, 32'h6, 1'b1);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h4505_0505;
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();
    chk("pair_drained", {31'h0, bus.instrD_valid}, 32'h0);

    // 32-bit instruction straddling two words
    expect_instr(32'h0000_4501, 32'h8, 1'b1);
    expect_instr(32'h0050_0093, 32'hA, 1'b0);
    expect_instr(32'h0000_ABCD, 32'hE, 1'b1);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0093_4501;
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    chk("straddle_wait", {31'h0, bus.instrD_valid}, 32'h0);
    tick();
    chk("straddle_hold", {31'h0, bus.instrD_valid}, 32'h0);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'hABCD_0050;
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();
    chk("straddle_done", {31'h0, bus.instrD_valid}, 32'h0);

    // Backpressure to full, then drain
    expect_instr(32'h0000_4501, 32'h10, 1'b1);
    expect_instr(32'h0000_4585, 32'h12, 1'b1);
    expect_instr(32'h0000_4505, 32'h14, 1'b1);
    expect_instr(32'h0000_0505, 32'h16, 1'b1);
    bus.instrD_ready = 1'b0;
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'h4585_4501;
    tick();
    chk("half_fetch_ready", {31'h0, bus.fetch_ready}, 32'h1);
    bus.fetch_data = 32'h0505_4505;
    tick();
    bus.fetch_valid = 1'b0;
    chk("full_fetch_ready", {31'h0, bus.fetch_ready}, 32'h0);
    chk("full_instrD", bus.instrD, 32'h0000_4501);
    tick();
    chk("held_instrD", bus.instrD, 32'h0000_4501);
    chk("held_pcD", bus.pcD, 32'h10);
    bus.instrD_ready = 1'b1;
    tick();
    chk("cnt3_fetch_ready", {31'h0, bus.fetch_ready}, 32'h0);
    tick();
    chk("cnt2_fetch_ready", {31'h0, bus.fetch_ready}, 32'h1);
    tick();
    tick();
    chk("drain_empty", {31'h0, bus.instrD_valid}, 32'h0);

    // Flush with three halfwords buffered and an incoming word
    expect_instr(32'h0000_0505, 32'h18, 1'b1);
    expect_instr(32'h0000_4585, 32'h102, 1'b1);
    bus.instrD_ready = 1'b0;
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'h4505_0505;
    tick();
    tick();
    bus.fetch_valid  = 1'b0;
    bus.instrD_ready = 1'b1;
    tick();
    bus.instrD_ready = 1'b0;
    bus.flush        = 1'b1;
    bus.flush_pc     = 32'h0000_0102;
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'hDEAD_BEEF;
    tick();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    chk("flush_valid", {31'h0, bus.instrD_valid}, 32'h0);
    chk("flush_pcD", bus.pcD, 32'h102);
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'h4585_1234;
    bus.instrD_ready = 1'b1;
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    chk("drop_first_only_upper", {31'h0, bus.instrD_valid}, 32'h0);

    // Back-to-back flushes: the last one wins
    expect_instr(32'h0000_0505, 32'h300, 1'b1);
    expect_instr(32'h0000_4505, 32'h302, 1'b1);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h0000_0202;
    tick();
    bus.flush_pc = 32'h0000_0300;
    tick();
    bus.flush = 1'b0;
    chk("b2b_pcD", bus.pcD, 32'h300);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h4505_0505;
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();

    // Reset beats a simultaneous flush
    expect_instr(32'h0050_0093, 32'h0, 1'b0);
    bus.instrD_ready = 1'b0;
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'h4505_0505;
    tick();
    bus.fetch_valid = 1'b0;
    reset           = 1'b1;
    bus.flush       = 1'b1;
    bus.flush_pc    = 32'h0000_0400;
    tick();
    reset     = 1'b0;
    bus.flush = 1'b0;
    chk("rst_flush_valid", {31'h0, bus.instrD_valid}, 32'h0);
    chk("rst_flush_pcD", bus.pcD, 32'h0);
    chk("rst_flush_fetch_ready", {31'h0, bus.fetch_ready}, 32'h1);
    bus.fetch_valid  = 1'b1;
    bus.fetch_data   = 32'h0050_0093;
    bus.instrD_ready = 1'b1;
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
